// File: rtl/soc_evt_collector_pkg.sv
// Shared types and constants for the SoC peripheral event collector.
package soc_evt_pkg;

    localparam int DEF_NB_SRC     = 32;
    localparam int DEF_EVNT_WIDTH = 8;
    localparam int DEF_ID_BASE    = 0;
    localparam int DEF_CNT_WIDTH  = 2;

    localparam int IDX_WIDTH = (DEF_NB_SRC > 1) ? $clog2(DEF_NB_SRC) : 1;

    typedef logic [DEF_EVNT_WIDTH-1:0] evt_id_t;

    // Largest value a saturating counter of the given width can hold.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/soc_evt_collector_if.sv
// Valid/ready/data stream carrying one event ID per transfer towards the
// event unit's SoC peripheral event FIFO.
interface soc_evt_collector_if #(
    parameter int EVNT_WIDTH = 8
);
    logic                  evt_valid;
    logic                  evt_ready;
    logic [EVNT_WIDTH-1:0] evt_data;

    modport master (
        output evt_valid,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        output evt_ready
    );
endinterface

// File: rtl/soc_evt_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting source at or after the
// pointer (wrapping), and moves the pointer past the winner on update.
module soc_evt_rr_arbiter
    import soc_evt_pkg::*;
#(
    parameter int NB_SRC = DEF_NB_SRC,
    parameter int IW     = (NB_SRC > 1) ? $clog2(NB_SRC) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_SRC-1:0] req_i,
    input  logic              update_i,
    output logic [IW-1:0]     winner_o,
    output logic              valid_o
);

    logic [IW-1:0] ptr_q;

    // Scan from the far end back to the pointer so the last hit is the
    // first requester in round-robin order.
    always_comb begin
        int idx;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int i = NB_SRC - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NB_SRC) idx = idx - NB_SRC;
            if (req_i[idx]) begin
                winner_o = IW'(idx);
                valid_o  = 1'b1;
            end
        end
    end

    // Pointer advances to the source after the winner whenever a grant is used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (update_i) begin
            if (int'(winner_o) == NB_SRC - 1) ptr_q <= '0;
            else                              ptr_q <= winner_o + IW'(1);
        end
    end

endmodule

// File: rtl/soc_evt_collector.sv
// SoC peripheral event collector: counts event pulses per source in
// saturating counters and forwards one event ID per transfer, arbitrating
// round-robin among enabled sources with pending events.
// Optional macro SOC_EVT_COLLECTOR_OVERFLOW_EN adds sticky per-source
// overflow flags (ovf_o) with a per-source clear (ovf_clr_i).
module soc_evt_collector
    import soc_evt_pkg::*;
#(
    parameter int NB_SRC     = DEF_NB_SRC,
    parameter int EVNT_WIDTH = DEF_EVNT_WIDTH,
    parameter int ID_BASE    = DEF_ID_BASE,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_SRC-1:0] src_evt_i,
    input  logic [NB_SRC-1:0] src_en_i,
    output logic [NB_SRC-1:0] pending_o,
`ifdef SOC_EVT_COLLECTOR_OVERFLOW_EN
    output logic [NB_SRC-1:0] ovf_o,
    input  logic [NB_SRC-1:0] ovf_clr_i,
`endif
    soc_evt_collector_if.master evt_if
);

    localparam int IW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    if (longint'(ID_BASE) + longint'(NB_SRC) > (longint'(1) << EVNT_WIDTH)) begin : g_id_range_check
        $error("soc_evt_collector: ID_BASE+NB_SRC exceeds the event ID space");
    end

    logic [CNT_WIDTH-1:0]  cnt_q [NB_SRC];
    logic [NB_SRC-1:0]     eligible;
    logic [NB_SRC-1:0]     inc;
    logic [NB_SRC-1:0]     dec;
    logic [IW-1:0]         winner;
    logic                  win_valid;
    logic                  load;
    logic                  valid_q;
    logic [EVNT_WIDTH-1:0] data_q;

    // Pending flags straight from the counter flops; disabled sources are
    // still counted as pending but never offered to the arbiter.
    always_comb begin
        for (int k = 0; k < NB_SRC; k++) begin
            pending_o[k] = (cnt_q[k] != '0);
        end
        eligible = pending_o & src_en_i;
        inc      = src_evt_i & src_en_i;
    end

    soc_evt_rr_arbiter #(
        .NB_SRC (NB_SRC),
        .IW     (IW)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (eligible),
        .update_i (load),
        .winner_o (winner),
        .valid_o  (win_valid)
    );

    // Load the output register whenever it is empty or being drained.
    always_comb begin
        dec  = '0;
        load = win_valid & (~valid_q | evt_if.evt_ready);
        if (load) dec[winner] = 1'b1;
    end

    // Saturating per-source counters; an event arriving as its own grant is
    // taken cancels out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NB_SRC; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NB_SRC; k++) begin
                if (inc[k] && !dec[k]) begin
                    if (cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
                end else if (dec[k] && !inc[k]) begin
                    cnt_q[k] <= cnt_q[k] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // Output register: held stable while stalled, cleared once accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= EVNT_WIDTH'(ID_BASE + int'(winner));
        end else if (evt_if.evt_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign evt_if.evt_valid = valid_q;
    assign evt_if.evt_data  = data_q;

`ifdef SOC_EVT_COLLECTOR_OVERFLOW_EN
    logic [NB_SRC-1:0] ovf_q;
    logic [NB_SRC-1:0] ovf_set;

    // An increment is dropped only when it is not cancelled by a grant.
    always_comb begin
        for (int k = 0; k < NB_SRC; k++) begin
            ovf_set[k] = inc[k] & ~dec[k] & (cnt_q[k] == CNT_MAX);
        end
    end

    // Sticky overflow flags; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) ovf_q <= '0;
        else       ovf_q <= (ovf_q & ~ovf_clr_i) | ovf_set;
    end

    assign ovf_o = ovf_q;
`endif

endmodule
